// File: rtl/alu_arbiter_if.sv
// Bundle between two ALU requesters, the arbiter and the shared combinational ALU.
// master: requester/ALU environment side; slave: the arbiter.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic        req0_arm;
  logic [3:0]  req0_ctrl;
  logic [31:0] req0_op1;
  logic [31:0] req0_op2;
  logic [2:0]  req0_shtype;
  logic [4:0]  req0_shamt;

  logic        req1_valid;
  logic        req1_ready;
  logic        req1_arm;
  logic [3:0]  req1_ctrl;
  logic [31:0] req1_op1;
  logic [31:0] req1_op2;
  logic [2:0]  req1_shtype;
  logic [4:0]  req1_shamt;

  logic        rsp0_valid;
  logic        rsp0_ready;
  logic [31:0] rsp0_result;
  logic [3:0]  rsp0_flags;

  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [31:0] rsp1_result;
  logic [3:0]  rsp1_flags;

  logic        alu_arm;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [2:0]  alu_shtype;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;

  modport master (
    output req0_valid, req0_arm, req0_ctrl, req0_op1, req0_op2, req0_shtype, req0_shamt,
    input  req0_ready,
    output req1_valid, req1_arm, req1_ctrl, req1_op1, req1_op2, req1_shtype, req1_shamt,
    input  req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_flags,
    output rsp0_ready,
    input  rsp1_valid, rsp1_result, rsp1_flags,
    output rsp1_ready,
    input  alu_arm, alu_ctrl, alu_op1, alu_op2, alu_shtype, alu_shamt,
    output alu_result, alu_flags
  );

  modport slave (
    input  req0_valid, req0_arm, req0_ctrl, req0_op1, req0_op2, req0_shtype, req0_shamt,
    output req0_ready,
    input  req1_valid, req1_arm, req1_ctrl, req1_op1, req1_op2, req1_shtype, req1_shamt,
    output req1_ready,
    output rsp0_valid, rsp0_result, rsp0_flags,
    input  rsp0_ready,
    output rsp1_valid, rsp1_result, rsp1_flags,
    input  rsp1_ready,
    output alu_arm, alu_ctrl, alu_op1, alu_op2, alu_shtype, alu_shamt,
    input  alu_result, alu_flags
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter for one shared combinational ALU: one-entry issue register,
// one response slot per requester, at most one outstanding operation per requester.
module alu_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input logic         clk,
  input logic         reset_n,
  alu_arbiter_if.slave bus
);

  logic        busy0;
  logic        busy1;
  logic        last_grant;
  logic        elig0;
  logic        elig1;
  logic        grant0;
  logic        grant1;
  logic        rsp0_xfer;
  logic        rsp1_xfer;
  logic        issue_on;

  logic        iss_valid;
  logic        iss_owner;
  logic        iss_arm;
  logic [3:0]  iss_ctrl;
  logic [31:0] iss_op1;
  logic [31:0] iss_op2;
  logic [2:0]  iss_shtype;
  logic [4:0]  iss_shamt;

  logic        rsp0_full;
  logic        rsp1_full;
  logic [31:0] rsp0_res;
  logic [31:0] rsp1_res;
  logic [3:0]  rsp0_flg;
  logic [3:0]  rsp1_flg;

  // Ready never looks at rsp*_ready; a requester becomes eligible only after its result left.
  always_comb begin
    elig0     = reset_n & bus.req0_valid & ~busy0;
    elig1     = reset_n & bus.req1_valid & ~busy1;
    grant0    = elig0 & (~elig1 | FIXED_PRIO | last_grant);
    grant1    = elig1 & ~grant0;
    rsp0_xfer = reset_n & rsp0_full & bus.rsp0_ready;
    rsp1_xfer = reset_n & rsp1_full & bus.rsp1_ready;
    issue_on  = reset_n & iss_valid;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy0      <= 1'b0;
      busy1      <= 1'b0;
      last_grant <= 1'b1;
      iss_valid  <= 1'b0;
      rsp0_full  <= 1'b0;
      rsp1_full  <= 1'b0;
    end else begin
      busy0     <= grant0 | (busy0 & ~rsp0_xfer);
      busy1     <= grant1 | (busy1 & ~rsp1_xfer);
      iss_valid <= grant0 | grant1;
      if (grant0 | grant1)
        last_grant <= grant1;
      if (iss_valid & ~iss_owner)
        rsp0_full <= 1'b1;
      else if (rsp0_xfer)
        rsp0_full <= 1'b0;
      if (iss_valid & iss_owner)
        rsp1_full <= 1'b1;
      else if (rsp1_xfer)
        rsp1_full <= 1'b0;
    end
  end

  // Datapath needs no reset: every field is qualified by a valid/full bit above.
  always_ff @(posedge clk) begin
    if (grant0) begin
      iss_owner  <= 1'b0;
      iss_arm    <= bus.req0_arm;
      iss_ctrl   <= bus.req0_ctrl;
      iss_op1    <= bus.req0_op1;
      iss_op2    <= bus.req0_op2;
      iss_shtype <= bus.req0_shtype;
      iss_shamt  <= bus.req0_shamt;
    end else if (grant1) begin
      iss_owner  <= 1'b1;
      iss_arm    <= bus.req1_arm;
      iss_ctrl   <= bus.req1_ctrl;
      iss_op1    <= bus.req1_op1;
      iss_op2    <= bus.req1_op2;
      iss_shtype <= bus.req1_shtype;
      iss_shamt  <= bus.req1_shamt;
    end
    if (iss_valid & ~iss_owner) begin
      rsp0_res <= bus.alu_result;
      rsp0_flg <= bus.alu_flags;
    end
    if (iss_valid & iss_owner) begin
      rsp1_res <= bus.alu_result;
      rsp1_flg <= bus.alu_flags;
    end
  end

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.rsp0_valid  = reset_n & rsp0_full;
  assign bus.rsp1_valid  = reset_n & rsp1_full;
  assign bus.rsp0_result = rsp0_res;
  assign bus.rsp1_result = rsp1_res;
  assign bus.rsp0_flags  = rsp0_flg;
  assign bus.rsp1_flags  = rsp1_flg;

  assign bus.alu_arm    = issue_on & iss_arm;
  assign bus.alu_ctrl   = issue_on ? iss_ctrl   : 4'd0;
  assign bus.alu_op1    = issue_on ? iss_op1    : 32'd0;
  assign bus.alu_op2    = issue_on ? iss_op2    : 32'd0;
  assign bus.alu_shtype = issue_on ? iss_shtype : 3'd0;
  assign bus.alu_shamt  = issue_on ? iss_shamt  : 5'd0;

endmodule
